// File: rtl/alu_exec_stage.sv
// Execute stage feeding the register-file write port: single-cycle ALU ops plus,
// when JAM_EX_MUL_EN is defined, an unsigned shift-add multiplier that stalls the stage.
`timescale 1ns/1ps
module alu_exec_stage #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    op,
    input  logic [AW-1:0] rd_in,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          wb_en,
    output logic [AW-1:0] wb_addr,
    output logic [W-1:0]  wb_data,
    output logic [3:0]    flags,
    output logic          busy
);

    logic [W-1:0] alu_res;
    logic         alu_c;
    logic         alu_v;
    logic         alu_wr;
    logic [W:0]   sum;
    logic [W:0]   diff;
    logic         accept;

    // Borrow for SUB falls out of the extra top bit: it is set exactly when a < b.
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_wr  = 1'b1;
        case (op)
            4'd0: begin
                alu_res = sum[W-1:0];
                alu_c   = sum[W];
                alu_v   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            4'd1: begin
                alu_res = diff[W-1:0];
                alu_c   = diff[W];
                alu_v   = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
            end
            4'd2: alu_res = a & b;
            4'd3: alu_res = a | b;
            4'd4: alu_res = a ^ b;
            4'd5: begin
                alu_res = {a[W-2:0], 1'b0};
                alu_c   = a[W-1];
            end
            4'd6: begin
                alu_res = {1'b0, a[W-1:1]};
                alu_c   = a[0];
            end
            4'd7: alu_res = b;
            default: alu_wr = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;

`ifdef JAM_EX_MUL_EN
    typedef enum logic {IDLE, MUL} state_t;

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    state_t          state;
    state_t          state_next;
    logic [2*W-1:0]  acc;
    logic [2*W-1:0]  mcand;
    logic [2*W-1:0]  acc_step;
    logic [W-1:0]    mplier;
    logic [CW-1:0]   iter;
    logic [AW-1:0]   mul_rd;
    logic            start_mul;
    logic            mul_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b1;
        busy       = 1'b0;
        start_mul  = 1'b0;
        mul_done   = 1'b0;
        acc_step   = acc + (mplier[0] ? mcand : '0);
        case (state)
            IDLE: begin
                if (in_valid && op == 4'd8) begin
                    start_mul  = 1'b1;
                    state_next = MUL;
                end
            end
            MUL: begin
                in_ready = 1'b0;
                busy     = 1'b1;
                if (iter == LAST_ITER) begin
                    mul_done   = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
    end

    // One partial product per clock; the final step's sum goes straight to writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            iter   <= '0;
            mul_rd <= '0;
        end else if (start_mul) begin
            acc    <= '0;
            mcand  <= {{W{1'b0}}, a};
            mplier <= b;
            iter   <= '0;
            mul_rd <= rd_in;
        end else if (state == MUL) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            iter   <= iter + CW'(1);
        end
    end
`else
    assign in_ready = 1'b1;
    assign busy     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
            flags   <= '0;
        end else begin
            wb_en <= 1'b0;
            if (accept && alu_wr) begin
                wb_en   <= 1'b1;
                wb_addr <= rd_in;
                wb_data <= alu_res;
                flags   <= {alu_res[W-1], alu_res == '0, alu_c, alu_v};
            end
`ifdef JAM_EX_MUL_EN
            else if (mul_done) begin
                wb_en   <= 1'b1;
                wb_addr <= mul_rd;
                wb_data <= acc_step[W-1:0];
                flags   <= {acc_step[W-1], acc_step[W-1:0] == '0, |acc_step[2*W-1:W], 1'b0};
            end
`endif
        end
    end

endmodule
